h_initiator: RTL and testbench

- Command initiator for the hash-table engine `h`; sits between a host requester and h's cmd/rsp interface.
- Accepts host requests on a valid/ready handshake and issues them to h's unflow-controlled cmd port.
- Limits in-flight work with a credit scheme, matches h's in-order responses to host-supplied IDs, and returns buffered completions on a valid/ready handshake.
- Provides a drain FSM so the host can quiesce the engine.

---
 rtl/h_initiator.sv | 160 ++++++++++++++++
 tb/tb_h_initiator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_initiator.sv
// Command initiator for the hash-table engine h: credit-limited issue of host
// requests, in-order tag matching of h responses, and a drain handshake.
package h_pkg;
  typedef logic [1:0]  opcode_t;
  typedef logic [7:0]  k_t;
  typedef logic [15:0] v_t;
  typedef logic [1:0]  status_t;
endpackage

module h_initiator #(
  parameter int MAX_INFLIGHT = 4,
  parameter int ID_W         = 4
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic                              req_vld,
  output logic                              req_rdy,
  input  h_pkg::opcode_t                    req_opcode,
  input  h_pkg::k_t                         req_k,
  input  h_pkg::v_t                         req_v,
  input  logic [ID_W-1:0]                   req_id,
  output logic                              cpl_vld,
  input  logic                              cpl_rdy,
  output h_pkg::status_t                    cpl_status,
  output h_pkg::v_t                         cpl_v,
  output logic [ID_W-1:0]                   cpl_id,
  output logic                              cmd_vld,
  output h_pkg::opcode_t                    cmd_opcode,
  output h_pkg::k_t                         cmd_k,
  output h_pkg::v_t                         cmd_v,
  input  logic                              rsp_vld,
  input  h_pkg::status_t                    rsp_status,
  input  h_pkg::v_t                         rsp_v,
  input  logic                              drain_req,
  output logic                              drain_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight,
  output logic                              o_err
);
  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // the payload must be stable while valid is high and ready is low.
  localparam int UW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $bits(h_pkg::status_t) + $bits(h_pkg::v_t) + ID_W;
  localparam logic [UW-1:0] MAX_U = UW'(MAX_INFLIGHT);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_INFLIGHT - 1);

  typedef enum logic {ST_ACTIVE, ST_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [UW-1:0]   used_q, used_d;
  logic            cmd_vld_q;
  h_pkg::opcode_t  cmd_opcode_q;
  h_pkg::k_t       cmd_k_q;
  h_pkg::v_t       cmd_v_q;
  logic            err_q;
  logic [ID_W-1:0] tag_mem_q [MAX_INFLIGHT];
  logic [PW-1:0]   tag_wr_q, tag_rd_q;
  logic [UW-1:0]   tag_cnt_q;
  logic [CW-1:0]   cq_mem_q [MAX_INFLIGHT];
  logic [PW-1:0]   cq_wr_q, cq_rd_q;
  logic [UW-1:0]   cq_cnt_q;

  logic accept, pop, rsp_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    req_rdy    = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        req_rdy = (used_q < MAX_U);
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (used_q == '0 && !cmd_vld_q) begin
          drain_done = 1'b1;
          state_d    = ST_ACTIVE;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  assign accept = req_vld && req_rdy;
  assign pop    = cpl_vld && cpl_rdy;
  // A response only counts when a tag is waiting; otherwise it is dropped.
  assign rsp_ok = rsp_vld && (tag_cnt_q != '0);

  always_comb begin
    used_d = used_q;
    case ({accept, pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_ACTIVE;
      used_q       <= '0;
      cmd_vld_q    <= 1'b0;
      cmd_opcode_q <= '0;
      cmd_k_q      <= '0;
      cmd_v_q      <= '0;
      err_q        <= 1'b0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      tag_cnt_q    <= '0;
      cq_wr_q      <= '0;
      cq_rd_q      <= '0;
      cq_cnt_q     <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        tag_mem_q[i] <= '0;
        cq_mem_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      used_q    <= used_d;
      cmd_vld_q <= accept;
      if (accept) begin
        cmd_opcode_q        <= req_opcode;
        cmd_k_q             <= req_k;
        cmd_v_q             <= req_v;
        tag_mem_q[tag_wr_q] <= req_id;
        tag_wr_q            <= ptr_inc(tag_wr_q);
      end
      if (rsp_vld && !rsp_ok) err_q <= 1'b1;
      if (rsp_ok) begin
        tag_rd_q          <= ptr_inc(tag_rd_q);
        cq_mem_q[cq_wr_q] <= {rsp_status, rsp_v, tag_mem_q[tag_rd_q]};
        cq_wr_q           <= ptr_inc(cq_wr_q);
      end
      if (pop) cq_rd_q <= ptr_inc(cq_rd_q);
      if (accept && !rsp_ok) tag_cnt_q <= tag_cnt_q + 1'b1;
      else if (!accept && rsp_ok) tag_cnt_q <= tag_cnt_q - 1'b1;
      if (rsp_ok && !pop) cq_cnt_q <= cq_cnt_q + 1'b1;
      else if (!rsp_ok && pop) cq_cnt_q <= cq_cnt_q - 1'b1;
    end
  end

  assign cmd_vld    = cmd_vld_q;
  assign cmd_opcode = cmd_opcode_q;
  assign cmd_k      = cmd_k_q;
  assign cmd_v      = cmd_v_q;
  assign cpl_vld    = (cq_cnt_q != '0);
  assign {cpl_status, cpl_v, cpl_id} = cq_mem_q[cq_rd_q];
  assign o_inflight = used_q;
  assign o_err      = err_q;

  // Credit is held until pop, so neither FIFO can ever be pushed while full.
  cq_overflow_a: assert property (@(posedge clk) disable iff (!arst_n)
    !(rsp_ok && !pop && cq_cnt_q == MAX_U));
  tag_overflow_a: assert property (@(posedge clk) disable iff (!arst_n)
    !(accept && !rsp_ok && tag_cnt_q == MAX_U));
endmodule

// File: tb/tb_h_initiator.sv
// Directed bench for h_initiator with a fixed-latency model of engine h and a
// completion scoreboard fed from accepted requests.
module tb_h_initiator;
  localparam int MAXI = 4;
  localparam int IDW  = 4;

  logic           clk = 1'b0;
  logic           arst_n;
  logic           req_vld, req_rdy, cpl_vld, cpl_rdy, cmd_vld, rsp_vld;
  h_pkg::opcode_t req_opcode, cmd_opcode;
  h_pkg::k_t      req_k, cmd_k;
  h_pkg::v_t      req_v, cmd_v, cpl_v, rsp_v;
  h_pkg::status_t cpl_status, rsp_status;
  logic [IDW-1:0] req_id, cpl_id;
  logic           drain_req, drain_done, o_err;
  logic [2:0]     o_inflight;

  int n_checks = 0;
  int n_errors = 0;
  logic [21:0] exp_q[$];
  logic [25:0] cmd_q[$];
  logic        acc, inject, pv0, pv1;
  logic [7:0]  pk0, pk1;
  int          nxt;

  always #5 clk = ~clk;

  h_initiator #(.MAX_INFLIGHT(MAXI), .ID_W(IDW)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_opcode(req_opcode),
    .req_k(req_k), .req_v(req_v), .req_id(req_id),
    .cpl_vld(cpl_vld), .cpl_rdy(cpl_rdy), .cpl_status(cpl_status),
    .cpl_v(cpl_v), .cpl_id(cpl_id),
    .cmd_vld(cmd_vld), .cmd_opcode(cmd_opcode), .cmd_k(cmd_k), .cmd_v(cmd_v),
    .rsp_vld(rsp_vld), .rsp_status(rsp_status), .rsp_v(rsp_v),
    .drain_req(drain_req), .drain_done(drain_done),
    .o_inflight(o_inflight), .o_err(o_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: score handshakes before the edge, then step the h model.
  task automatic tick();
    acc = req_vld && req_rdy;
    if (acc) begin
      exp_q.push_back({req_k[1:0], req_k, ~req_k, req_id});
      cmd_q.push_back({req_opcode, req_k, req_v});
    end
    if (cpl_vld && cpl_rdy) begin
      if (exp_q.size() == 0) check("cpl_unexpected", 32'd0, 32'd1);
      else check("cpl", {10'd0, cpl_status, cpl_v, cpl_id}, {10'd0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
    if (cmd_vld) begin
      if (cmd_q.size() == 0) check("cmd_unexpected", 32'd0, 32'd1);
      else check("cmd", {6'd0, cmd_opcode, cmd_k, cmd_v}, {6'd0, cmd_q.pop_front()});
    end
    rsp_vld    = pv1 | inject;
    rsp_status = inject ? 2'd3 : pk1[1:0];
    rsp_v      = inject ? 16'hdead : {pk1, ~pk1};
    pv1 = pv0; pk1 = pk0;
    pv0 = cmd_vld; pk0 = cmd_k;
    inject = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] id, input logic [7:0] k);
    req_id = id; req_k = k; req_opcode = id[1:0]; req_v = {~k, k};
  endtask

  task automatic send(input logic [3:0] id, input logic [7:0] k);
    set_req(id, k);
    req_vld = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick();
    check("send_accept", {31'd0, acc}, 32'd1);
    req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && o_inflight != 3'd0; i++) tick();
    check("idle_inflight", {29'd0, o_inflight}, 32'd0);
  endtask

  initial begin
    arst_n = 1'b0; req_vld = 1'b0; cpl_rdy = 1'b0; drain_req = 1'b0;
    rsp_vld = 1'b0; rsp_status = '0; rsp_v = '0; inject = 1'b0;
    pv0 = 1'b0; pv1 = 1'b0; pk0 = '0; pk1 = '0; acc = 1'b0;
    set_req(4'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
    check("rst_cpl_vld", {31'd0, cpl_vld}, 32'd0);
    check("rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
    check("rst_inflight", {29'd0, o_inflight}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_drain_done", {31'd0, drain_done}, 32'd0);
    arst_n = 1'b1;
    tick();

    // single request: accept at N, cmd at N+1, rsp at N+3, cpl at N+4
    set_req(4'd3, 8'h10);
    req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
    check("single_acc", {31'd0, acc}, 32'd1);
    check("single_cmd_vld", {31'd0, cmd_vld}, 32'd1);
    check("single_cmd_k", {24'd0, cmd_k}, 32'h10);
    check("single_inflight", {29'd0, o_inflight}, 32'd1);
    tick();
    check("single_cmd_once", {31'd0, cmd_vld}, 32'd0);
    tick();
    check("single_rsp_n3", {31'd0, rsp_vld}, 32'd1);
    check("single_no_cpl_yet", {31'd0, cpl_vld}, 32'd0);
    tick();
    check("single_cpl_vld", {31'd0, cpl_vld}, 32'd1);
    check("single_cpl_id", {28'd0, cpl_id}, 32'd3);
    check("single_cpl_v", {16'd0, cpl_v}, 32'h10ef);
    cpl_rdy = 1'b1;
    tick();
    check("single_inflight0", {29'd0, o_inflight}, 32'd0);
    check("single_cpl_gone", {31'd0, cpl_vld}, 32'd0);

    // credit limit and simultaneous accept/pop
    cpl_rdy = 1'b0;
    nxt = 0;
    set_req(4'd0, 8'h20);
    req_vld = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (acc) begin nxt++; set_req(4'(nxt), 8'(8'h20 + nxt)); end
    end
    check("credit_accepted", nxt, 32'd4);
    check("credit_inflight4", {29'd0, o_inflight}, 32'd4);
    check("credit_rdy0", {31'd0, req_rdy}, 32'd0);
    check("credit_head_id", {28'd0, cpl_id}, 32'd0);
    cpl_rdy = 1'b1;
    tick();
    check("credit_pop_only", {31'd0, acc}, 32'd0);
    check("credit_inflight3", {29'd0, o_inflight}, 32'd3);
    check("credit_rdy1", {31'd0, req_rdy}, 32'd1);
    tick();
    check("both_at3_acc", {31'd0, acc}, 32'd1);
    check("both_at3_inflight", {29'd0, o_inflight}, 32'd3);
    set_req(4'd5, 8'h25);
    tick();
    check("both_again_acc", {31'd0, acc}, 32'd1);
    check("both_again_inflight", {29'd0, o_inflight}, 32'd3);
    req_vld = 1'b0;
    wait_idle();

    // completion backpressure
    cpl_rdy = 1'b0;
    send(4'd0, 8'h30);
    send(4'd1, 8'h31);
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_vld", {31'd0, cpl_vld}, 32'd1);
      check("bp_id", {28'd0, cpl_id}, 32'd0);
      check("bp_v", {16'd0, cpl_v}, 32'h30cf);
    end
    cpl_rdy = 1'b1;
    tick();
    check("bp_next_vld", {31'd0, cpl_vld}, 32'd1);
    check("bp_next_id", {28'd0, cpl_id}, 32'd1);
    tick();
    check("bp_empty", {31'd0, cpl_vld}, 32'd0);

    // drain with two outstanding
    cpl_rdy = 1'b0;
    send(4'd7, 8'h40);
    send(4'd8, 8'h41);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("drain_rdy0", {31'd0, req_rdy}, 32'd0);
    repeat (6) tick();
    check("drain_hold_rdy", {31'd0, req_rdy}, 32'd0);
    check("drain_hold_done", {31'd0, drain_done}, 32'd0);
    cpl_rdy = 1'b1;
    tick();
    check("drain_one_left", {31'd0, drain_done}, 32'd0);
    tick();
    check("drain_done", {31'd0, drain_done}, 32'd1);
    check("drain_done_rdy", {31'd0, req_rdy}, 32'd0);
    tick();
    check("drain_pulse_end", {31'd0, drain_done}, 32'd0);
    check("drain_rdy_back", {31'd0, req_rdy}, 32'd1);

    // drain while idle
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("idle_drain_done", {31'd0, drain_done}, 32'd1);
    check("idle_drain_rdy", {31'd0, req_rdy}, 32'd0);
    tick();
    check("idle_drain_end", {31'd0, drain_done}, 32'd0);

    // request accepted in the drain_req cycle is still issued
    set_req(4'd9, 8'h50);
    req_vld = 1'b1; drain_req = 1'b1;
    tick();
    req_vld = 1'b0; drain_req = 1'b0;
    check("drain_same_acc", {31'd0, acc}, 32'd1);
    check("drain_same_cmd", {31'd0, cmd_vld}, 32'd1);
    check("drain_same_rdy", {31'd0, req_rdy}, 32'd0);
    for (int i = 0; i < 12 && !drain_done; i++) tick();
    check("drain_same_done", {31'd0, drain_done}, 32'd1);
    check("drain_same_idle", {29'd0, o_inflight}, 32'd0);

    // stray response
    inject = 1'b1;
    tick();
    tick();
    check("err_set", {31'd0, o_err}, 32'd1);
    check("err_no_cpl", {31'd0, cpl_vld}, 32'd0);
    tick();
    check("err_sticky", {31'd0, o_err}, 32'd1);

    // reset mid-traffic
    cpl_rdy = 1'b0;
    send(4'd2, 8'h60);
    send(4'd4, 8'h61);
    arst_n = 1'b0;
    #1;
    check("arst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
    check("arst_cmd_k", {24'd0, cmd_k}, 32'd0);
    check("arst_inflight", {29'd0, o_inflight}, 32'd0);
    check("arst_err", {31'd0, o_err}, 32'd0);
    check("arst_cpl_vld", {31'd0, cpl_vld}, 32'd0);
    check("arst_req_rdy", {31'd0, req_rdy}, 32'd1);
    exp_q.delete(); cmd_q.delete();
    pv0 = 1'b0; pv1 = 1'b0; rsp_vld = 1'b0;
    #2;
    arst_n = 1'b1;
    tick();
    cpl_rdy = 1'b1;
    send(4'd5, 8'h55);
    wait_idle();
    repeat (2) tick();
    check("end_exp_empty", exp_q.size(), 32'd0);
    check("end_cmd_empty", cmd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
